// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: fetch entry layout, the canonical NOP and base opcodes.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013; // addi x0, x0, 0

    // Base RV32I major opcodes, consumed by decode's control_unit.
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO with flush; holds fetch entries or, at a narrower width,
// the PCs of in-flight instruction-memory requests.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned Width = $bits(fetch_entry_t)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic [1:0]       cnt_o
);

    logic [Width-1:0] mem_q [0:1];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (cnt_q != 2'd0);
    // When full, a push can only land in the slot being vacated this cycle.
    assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is cleared only on reset so the idle head reads as zero afterwards.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o = mem_q[rd_ptr_q];
    assign cnt_o  = cnt_q;

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        push_i && !flush_i |-> (cnt_q != 2'd2) || pop_i);

endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch stage: PC, credit-limited imem requests, 2-entry IF/ID queue and
// redirect handling that discards stale in-flight responses. ADDR_W/INSTR_W <= XLEN.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               stall,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [ADDR_W-1:0]  if_id_pc4
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        drop_q, drop_d;
    logic [1:0]        outst;
    logic [1:0]        cnt;
    logic [2:0]        credit;
    logic [ADDR_W-1:0] inflight_pc;
    logic              req_fire, rsp_fire, pop, keep_rsp;
    fetch_entry_t      rsp_entry, head_entry;

    assign rsp_fire    = imem_rsp_valid;
    assign if_id_valid = (cnt != 2'd0);
    assign pop         = if_id_valid && !stall && !redirect_valid;

    // Every request in flight or word queued holds a slot; a new request needs a free one.
    assign credit         = {1'b0, outst} + {1'b0, cnt} - {2'b00, pop};
    assign imem_req_valid = rst_n && !redirect_valid && (credit < 3'd2);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign keep_rsp = rsp_fire && !redirect_valid && (drop_q == 2'd0);

    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q;
        if (redirect_valid) begin
            pc_d   = redirect_pc & ~ADDR_W'(3);
            drop_d = outst - {1'b0, rsp_fire};
        end else begin
            if (req_fire) begin
                pc_d = pc_q + ADDR_W'(4);
            end
            if (rsp_fire && (drop_q != 2'd0)) begin
                drop_d = drop_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            drop_q <= 2'd0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

    // PCs of accepted requests; its occupancy is the outstanding count, dropped ones included.
    fetch_fifo #(
        .Width(ADDR_W)
    ) u_inflight_q (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .flush_i    (1'b0),
        .push_i     (req_fire),
        .push_data_i(pc_q),
        .pop_i      (rsp_fire),
        .head_o     (inflight_pc),
        .cnt_o      (outst)
    );

    always_comb begin
        rsp_entry       = '0;
        rsp_entry.pc    = XLEN'(inflight_pc);
        rsp_entry.instr = XLEN'(imem_rsp_data);
    end

    fetch_fifo #(
        .Width($bits(fetch_entry_t))
    ) u_if_id_q (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .flush_i    (redirect_valid),
        .push_i     (keep_rsp),
        .push_data_i(rsp_entry),
        .pop_i      (pop),
        .head_o     (head_entry),
        .cnt_o      (cnt)
    );

    assign if_id_instr = if_id_valid ? INSTR_W'(head_entry.instr) : INSTR_W'(NOP_INSTR);
    assign if_id_pc    = ADDR_W'(head_entry.pc);
    assign if_id_pc4   = if_id_pc + ADDR_W'(4);

    assert property (@(posedge clk) disable iff (!rst_n) rsp_fire |-> outst != 2'd0);
    assert property (@(posedge clk) disable iff (!rst_n) drop_q <= outst);
    assert property (@(posedge clk) disable iff (!rst_n)
        imem_req_valid && !imem_req_ready |=> imem_req_addr == $past(imem_req_addr));

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch stage of the pipelined RV32I core. Keeps the program counter, issues in-order instruction-memory requests over a valid/ready handshake, and buffers returned words in a 2-entry queue. It presents the queue head to decode as the IF/ID register, so decode's `control_unit` consumes `if_id_instr[6:0]/[14:12]/[31:25]`. It also handles EX-stage redirects (taken branch, JAL, JALR) by discarding stale in-flight responses.

## Interface
- `ADDR_W`, 32, PC/address width
- `INSTR_W`, 32, instruction width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous and active-low
- `imem_req_valid`  out  1  request valid
- `imem_req_addr`  out  ADDR_W  request address; word aligned
- `imem_req_ready`  in  1  memory accepts request
- `imem_rsp_valid`  in  1  response valid; no backpressure
- `imem_rsp_data`  in  INSTR_W  instruction word
- `redirect_valid`  in  1  EX redirect (branch taken / jump)
- `redirect_pc`  in  ADDR_W  redirect target; bits [1:0] ignored and treated as 0
- `stall`  in  1  decode holds IF/ID (hazard unit)
- `if_id_valid`  out  1  IF/ID holds a live instruction
- `if_id_instr`  out  INSTR_W  instruction; forced to 32'h0000_0013 (NOP) when `if_id_valid`=0
- `if_id_pc`  out  ADDR_W  PC of `if_id_instr`
- `if_id_pc4`  out  ADDR_W  `if_id_pc`+4, modulo 2^ADDR_W

## Operation
- State:
  - `pc_q`: next fetch address.
  - `outst`: requests accepted but not yet answered, 0..2, including ones to be dropped.
  - `drop`: responses still to discard, 0..2.
  - 2-entry FIFO of {pc, instr}; `cnt` 0..2.
- `req_fire` = `imem_req_valid & imem_req_ready`.
- `rsp_fire` = `imem_rsp_valid`.
- `pop` = `if_id_valid & ~stall & ~redirect_valid`.
- Request issue:
  - `imem_req_valid` = `~redirect_valid & (outst + cnt - pop < 2)`. The credit rule guarantees every kept response has a FIFO slot.
  - `imem_req_addr` = `pc_q`.
  - On `req_fire`, `pc_q` += 4, wrapping modulo 2^ADDR_W.
  - `valid` must not depend on `ready`. Once asserted, `addr` is held until accepted, unless a redirect occurs.
- Response:
  - Responses are in order.
  - If `drop`>0, the word is discarded and `drop` decrements.
  - Otherwise the word is pushed with its PC. The PC comes from a 2-deep in-flight PC queue written on `req_fire`.
  - `outst` += `req_fire` − `rsp_fire`.
- Redirect (highest priority):
  - Next cycle: `pc_q`=`redirect_pc`&~3, FIFO emptied, `if_id_valid`=0.
  - `drop` = `outst` − `rsp_fire`; any response in the redirect cycle is also discarded.
  - No request issues in the redirect cycle.
  - Redirect while `drop`>0 is legal; the same formula applies.
- Stall: the FIFO head is held and responses still enqueue. Redirect overrides stall.
- Simultaneous push and pop with `cnt`=2 cannot occur (credit rule). Push+pop at `cnt`=1 leaves `cnt`=1.
- Reset (`rst_n`=0 at edge):
  - `pc_q`=RESET_PC; `outst`, `drop`, `cnt` all 0.
  - `imem_req_valid`=0 while `rst_n`=0.
  - `if_id_valid`=0, `if_id_instr`=NOP, `if_id_pc`=0, `if_id_pc4`=4.
  - Responses from before reset are not expected. Memory is reset alongside.

## Timing
- First request: first cycle after `rst_n` rises, addr RESET_PC.
- Latency: `req_fire` at cycle t, with 1-cycle memory `rsp` at t+1, gives `if_id_valid` at t+2.
- Throughput: 1 instr/cycle with 1-cycle memory and no stall.
- Redirect asserted in cycle r:
  - `if_id_valid`=0 in r+1.
  - Request to target in r+1.
  - First target instruction visible at r+3 (1-cycle memory).
- `if_id_*` are register outputs except the NOP mux.
- Combinational paths: `stall`/`redirect_valid` → `imem_req_valid`. The deepest path is `pop` through the credit compare.

## Structure
- `riscv_pkg` holds `NOP_INSTR` (32'h0000_0013) and the `fetch_entry_t` struct {pc, instr}. Opcode constants used by decode also move there.
- One sub-module: `fetch_fifo`, a 2-entry synchronous FIFO of `fetch_entry_t` with push/pop/flush and count. The in-flight PC queue reuses it.

## Test plan
- Reset, `RESET_PC`=0x100, memory always ready, 1-cycle latency → requests 0x100, 0x104, 0x108 in consecutive cycles; `if_id_pc` 0x100 two cycles after first request, then +4 each cycle; `if_id_pc4` 0x104.
- `stall` held 4 cycles mid-stream → `if_id` constant; `imem_req_valid` drops once `outst+cnt`=2; no instruction lost or duplicated after release.
- `imem_req_ready` low 3 cycles → `imem_req_addr` stable; `pc_q` does not advance.
- Redirect to 0x203 with 2 outstanding → next request 0x200; both stale responses discarded; first new `if_id_pc`=0x200.
- Redirect coincident with `stall` and a response → redirect wins; FIFO flushed; that response dropped; `drop`=1.
- `rst_n` low mid-stream with outstanding requests → next cycle `if_id_valid`=0, `if_id_instr`=0x00000013, first request after release is `RESET_PC`.
